// File: rtl/vga_pkg.sv
// Frame-buffer geometry shared by the UART row writer and the VGA scan-out.
package vga_pkg;
    localparam int Wight     = 640;
    localparam int Height    = 480;
    localparam int PIX_BITS  = 3;
    localparam int WORD_PIX  = 8;
    localparam int WORDS_ROW = Wight / WORD_PIX;
    localparam int ADDR_W    = 16;

    localparam int ROW_IDX_W = 9;
    localparam int ROW_BITS  = PIX_BITS * Wight;
    localparam int WORD_BITS = PIX_BITS * WORD_PIX;
    localparam int K_W       = $clog2(WORDS_ROW);

    localparam logic [ROW_IDX_W-1:0] ROW_LIMIT = ROW_IDX_W'(Height);
    localparam logic [ROW_IDX_W-1:0] ROW_LAST  = ROW_IDX_W'(Height - 1);
    localparam logic [K_W-1:0]       K_LAST    = K_W'(WORDS_ROW - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} fb_wr_state_t;

    // Word k of a packed row; pixel 8k lands in the LSBs.
    function automatic logic [WORD_BITS-1:0] row_word(input logic [ROW_BITS-1:0] row,
                                                      input logic [K_W-1:0] k);
        return row[int'(k)*WORD_BITS +: WORD_BITS];
    endfunction
endpackage

// File: rtl/pos_edge.sv
// Rising-edge detector; the first cycle after reset only primes the history bit.
module pos_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic in_q;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q  <= in;
            armed <= 1'b1;
        end
    end

    assign rise = armed && in && !in_q;
endmodule

// File: rtl/uart_row_fb_writer.sv
// Captures completed UART pixel rows and streams them into the frame buffer as packed words.
module uart_row_fb_writer
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROW_IDX_W-1:0] row_in,
    input  logic [ROW_BITS-1:0]  row_data_in,
    input  logic                 row_done_in,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [WORD_BITS-1:0] mem_wr_data,
    input  logic                 mem_wr_ready,
    output logic                 busy,
    output logic                 row_written,
    output logic                 frame_done,
    output logic                 err_row_range,
    output logic                 err_overrun
);
    fb_wr_state_t         state;
    logic                 rise;
    logic [K_W-1:0]       k;
    logic [K_W-1:0]       k_inc;
    logic [ROW_IDX_W-1:0] row_q;
    logic [ROW_BITS-1:0]  row_data_q;
    logic [ADDR_W-1:0]    base;

    pos_edge u_rise (
        .clk  (clk),
        .rst  (rst),
        .in   (row_done_in),
        .rise (rise)
    );

    assign k_inc = k + K_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            row_q         <= '0;
            row_data_q    <= '0;
            base          <= '0;
            mem_wr_en     <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            busy          <= 1'b0;
            row_written   <= 1'b0;
            frame_done    <= 1'b0;
            err_row_range <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            row_written   <= 1'b0;
            frame_done    <= 1'b0;
            err_row_range <= 1'b0;
            err_overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        if (row_in < ROW_LIMIT) begin
                            row_q       <= row_in;
                            row_data_q  <= row_data_in;
                            base        <= ADDR_W'(row_in) * ADDR_W'(WORDS_ROW);
                            mem_wr_addr <= ADDR_W'(row_in) * ADDR_W'(WORDS_ROW);
                            mem_wr_data <= row_data_in[WORD_BITS-1:0];
                            k           <= '0;
                            mem_wr_en   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            err_row_range <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (rise) err_overrun <= 1'b1;
                    if (mem_wr_ready) begin
                        if (k == K_LAST) begin
                            mem_wr_en   <= 1'b0;
                            row_written <= 1'b1;
                            frame_done  <= (row_q == ROW_LAST);
                            state       <= DONE;
                        end else begin
                            k           <= k_inc;
                            mem_wr_addr <= base + ADDR_W'(k_inc);
                            mem_wr_data <= row_word(row_data_q, k_inc);
                        end
                    end
                end
                DONE: begin
                    if (rise) err_overrun <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
